// File: rtl/wordle_pkg.sv
// Shared constants, tile types and scorer state encoding for the Wordle scorer slice.
package wordle_pkg;

  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 5;
  localparam int LETTER_W = 8;
  localparam int WORD_W   = NUM_COLS * LETTER_W;

  typedef logic [2:0]          color_t;
  typedef logic [LETTER_W-1:0] letter_t;

  // Tile colors as {R,G,B}
  localparam color_t COLOR_EMPTY  = 3'b000;
  localparam color_t COLOR_GREEN  = 3'b010;
  localparam color_t COLOR_YELLOW = 3'b110;
  localparam color_t COLOR_ABSENT = 3'b111;

  localparam letter_t BLANK_LETTER = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_WRITE,
    S_OVER
  } state_t;

  // Letter idx of a packed word; idx 0 is the leftmost letter in the top byte.
  function automatic letter_t word_letter(input logic [WORD_W-1:0] word, input int idx);
    return word[WORD_W-1-idx*LETTER_W -: LETTER_W];
  endfunction

endpackage

// File: rtl/wordle_hist_ram.sv
// 6x5 tile history (color + letter) with bulk clear, one-row write and a registered read port.
module wordle_hist_ram
  import wordle_pkg::*;
(
  input  logic                       board_clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_row,
  input  color_t  [NUM_COLS-1:0]     wr_colors,
  input  letter_t [NUM_COLS-1:0]     wr_letters,
  input  logic [2:0]                 rd_row,
  input  logic [2:0]                 rd_col,
  output color_t                     rd_color,
  output letter_t                    rd_letter
);

  color_t  tile_color  [NUM_ROWS][NUM_COLS];
  letter_t tile_letter [NUM_ROWS][NUM_COLS];

  logic rd_in_range;

  // NOTE: this storage is reset explicitly because a new board must read as blank tiles;
  // a plain data RAM would normally be left unreset so it can map onto memory macros.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          tile_color[r][c]  <= COLOR_EMPTY;
          tile_letter[r][c] <= BLANK_LETTER;
        end
      end
    end else if (clear) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          tile_color[r][c]  <= COLOR_EMPTY;
          tile_letter[r][c] <= BLANK_LETTER;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        tile_color[wr_row][c]  <= wr_colors[c];
        tile_letter[wr_row][c] <= wr_letters[c];
      end
    end
  end

  assign rd_in_range = (rd_row < 3'(NUM_ROWS)) && (rd_col < 3'(NUM_COLS));

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      rd_color  <= COLOR_EMPTY;
      rd_letter <= BLANK_LETTER;
    end else if (rd_in_range) begin
      rd_color  <= tile_color[rd_row][rd_col];
      rd_letter <= tile_letter[rd_row][rd_col];
    end else begin
      rd_color  <= COLOR_EMPTY;
      rd_letter <= BLANK_LETTER;
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// Scores five-letter guesses against a target (green pass, then one yellow position per cycle)
// and commits each scored row into the tile history.
module wordle_guess_scorer
  import wordle_pkg::*;
(
  input  logic              board_clk,
  input  logic              reset,
  input  logic              new_game,
  input  logic              guess_valid,
  output logic              guess_ready,
  input  logic [WORD_W-1:0] guess_word,
  input  logic [WORD_W-1:0] target_word,
  input  logic [2:0]        rd_row,
  input  logic [2:0]        rd_col,
  output logic [2:0]        rd_color,
  output logic [7:0]        rd_letter,
  output logic              score_done,
  output logic              win,
  output logic              lose,
  output logic [2:0]        guess_count
);

  localparam logic [2:0] LAST_POS = 3'(NUM_COLS - 1);
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  state_t state, next_state;

  letter_t             guess_q  [NUM_COLS];
  letter_t             target_q [NUM_COLS];
  color_t              colors_q [NUM_COLS];
  logic [NUM_COLS-1:0] used_q;
  logic [2:0]          pos_q;
  logic [2:0]          count_q;
  logic                win_q, lose_q, done_q;

  color_t              green_colors [NUM_COLS];
  logic [NUM_COLS-1:0] green_used;
  logic                yellow_hit;
  logic [NUM_COLS-1:0] yellow_take;
  logic                all_green, win_next, lose_next;
  logic                wr_en;

  color_t  [NUM_COLS-1:0] wr_colors;
  letter_t [NUM_COLS-1:0] wr_letters;

  // Green pass: every position compared in parallel; non-green tiles start as ABSENT.
  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      green_colors[i] = COLOR_ABSENT;
      green_used[i]   = 1'b0;
      if (guess_q[i] == target_q[i]) begin
        green_colors[i] = COLOR_GREEN;
        green_used[i]   = 1'b1;
      end
    end
  end

  // Yellow step for position pos_q: descending scan so the lowest unused match wins.
  always_comb begin
    yellow_hit  = 1'b0;
    yellow_take = '0;
    if (colors_q[pos_q] != COLOR_GREEN) begin
      for (int j = NUM_COLS - 1; j >= 0; j--) begin
        if (!used_q[j] && (target_q[j] == guess_q[pos_q])) begin
          yellow_hit     = 1'b1;
          yellow_take    = '0;
          yellow_take[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    all_green = 1'b1;
    for (int i = 0; i < NUM_COLS; i++) begin
      all_green = all_green & (colors_q[i] == COLOR_GREEN);
    end
    win_next  = all_green;
    lose_next = !all_green && (count_q == LAST_ROW);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state  = state;
    guess_ready = 1'b0;
    wr_en       = 1'b0;
    unique case (state)
      S_IDLE: begin
        guess_ready = 1'b1;
        if (guess_valid) next_state = S_GREEN;
      end
      S_GREEN:  next_state = S_YELLOW;
      S_YELLOW: if (pos_q == LAST_POS) next_state = S_WRITE;
      S_WRITE: begin
        wr_en      = 1'b1;
        next_state = (win_next || lose_next) ? S_OVER : S_IDLE;
      end
      S_OVER:   next_state = S_OVER;
      default:  next_state = S_IDLE;
    endcase
    // new_game aborts everything, including a commit in WRITE.
    if (new_game) begin
      next_state = S_IDLE;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        guess_q[i]  <= '0;
        target_q[i] <= '0;
        colors_q[i] <= COLOR_EMPTY;
      end
      used_q  <= '0;
      pos_q   <= '0;
      count_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (new_game) begin
        used_q  <= '0;
        pos_q   <= '0;
        count_q <= '0;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (guess_valid) begin
              for (int i = 0; i < NUM_COLS; i++) begin
                guess_q[i]  <= word_letter(guess_word, i);
                target_q[i] <= word_letter(target_word, i);
              end
              used_q <= '0;
              pos_q  <= '0;
            end
          end
          S_GREEN: begin
            for (int i = 0; i < NUM_COLS; i++) colors_q[i] <= green_colors[i];
            used_q <= green_used;
          end
          S_YELLOW: begin
            if (yellow_hit) colors_q[pos_q] <= COLOR_YELLOW;
            used_q <= used_q | yellow_take;
            pos_q  <= pos_q + 3'd1;
          end
          S_WRITE: begin
            count_q <= count_q + 3'd1;
            win_q   <= win_next;
            lose_q  <= lose_next;
            done_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      wr_colors[i]  = colors_q[i];
      wr_letters[i] = guess_q[i];
    end
  end

  wordle_hist_ram u_hist (
    .board_clk  (board_clk),
    .reset      (reset),
    .clear      (new_game),
    .wr_en      (wr_en),
    .wr_row     (count_q),
    .wr_colors  (wr_colors),
    .wr_letters (wr_letters),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_color   (rd_color),
    .rd_letter  (rd_letter)
  );

  assign score_done  = done_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign guess_count = count_q;

endmodule

// File: doc/wordle_guess_scorer.md
WORDLE_GUESS_SCORER -- requirements
Module: wordle_guess_scorer

Interface
REQ-001 SHALL have port board_clk, input, 1, system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port new_game, input, 1, one-cycle pulse; clears history and flags.
REQ-004 SHALL have port guess_valid, input, 1, submitted guess present.
REQ-005 SHALL have port guess_ready, output, 1, scorer can accept a guess.
REQ-006 SHALL have port guess_word, input, 40, five ASCII letters; [39:32] is the first letter.
REQ-007 SHALL have port target_word, input, 40, secret word, same byte order as guess_word.
REQ-008 SHALL have port rd_row, input, 3, history read row (0-5).
REQ-009 SHALL have port rd_col, input, 3, history read column (0-4).
REQ-010 SHALL have port rd_color, output, 3, {R,G,B} of the addressed tile.
REQ-011 SHALL have port rd_letter, output, 8, ASCII letter of the addressed tile.
REQ-012 SHALL have port score_done, output, 1, one-cycle pulse when a row is committed.
REQ-013 SHALL have port win, output, 1, last committed guess was all green.
REQ-014 SHALL have port lose, output, 1, six guesses committed without a win.
REQ-015 SHALL have port guess_count, output, 3, committed rows, range 0-6.

Function
REQ-016 SHALL use tile colors EMPTY=000, GREEN=010, YELLOW=110, ABSENT=111.
REQ-017 SHALL implement the states IDLE, GREEN, YELLOW, WRITE and OVER.
REQ-018 SHALL drive guess_ready=1 only in IDLE.
REQ-019 SHALL accept a guess on the edge where guess_valid & guess_ready are both high, latching guess_word and target_word on that edge.
REQ-020 SHALL, in GREEN (1 cycle), compare all 5 positions in parallel, mark equal positions GREEN, and mark the matching target positions used.
REQ-021 SHALL, in YELLOW (5 cycles, position 0..4, one per cycle), mark a non-green position YELLOW if an unused target position holds the same letter, consuming the lowest such index; otherwise mark it ABSENT.
REQ-022 SHALL, in WRITE (1 cycle), write 5 colors and 5 letters into row guess_count, increment guess_count, and pulse score_done.
REQ-023 SHALL raise score_done exactly 7 cycles after the accepting edge.
REQ-024 SHALL update win and lose on the same edge that raises score_done.
REQ-025 SHALL, after WRITE, go to OVER if win or lose is set, else return to IDLE.
REQ-026 SHALL, in OVER, hold guess_ready=0 and ignore guess_valid until new_game.
REQ-027 SHALL, on new_game in any state, abort any scoring in progress, suppress score_done, and clear all tiles to EMPTY with letter 8'h20.
REQ-028 SHALL, on new_game, clear guess_count, win and lose, and enter IDLE next cycle.
REQ-029 SHALL give new_game priority over guess_valid in the same cycle.
REQ-030 SHALL provide a registered read port with 1-cycle latency from rd_row/rd_col to rd_color/rd_letter.
REQ-031 SHALL return rd_color=000 and rd_letter=8'h20 for rd_row>5 or rd_col>4.
REQ-032 SHALL not guard against a read of a row in the cycle it is written; such a read may return either the old or the new data.
REQ-033 SHALL keep guess_word and target_word changes after acceptance from affecting the result in progress.

Reset
REQ-034 SHALL, on reset, go to IDLE and clear every tile to EMPTY/8'h20.
REQ-035 SHALL, on reset, set guess_count=0, win=0, lose=0, score_done=0, rd_color=000 and rd_letter=8'h20.
REQ-036 SHALL assert guess_ready=1 on the first clock after reset deasserts.
REQ-037 SHALL, on reset mid-scoring, discard the partial row without committing it.

Structure
REQ-038 SHALL place the color constants, NUM_ROWS=6, NUM_COLS=5, LETTER_W=8 and the state encoding in shared package wordle_pkg.
REQ-039 SHALL implement the 6x5 tile storage and registered read port as sub-module wordle_hist_ram.
REQ-040 SHALL keep the scoring FSM and used-mask in the top module.

Verification
REQ-041 SHALL verify: target "CRANE", guess "CRANE" -> row0 = 010 x5; win=1 and guess_count=1 at cycle 7; guess_ready stays 0.
REQ-042 SHALL verify: target "APPLE", guess "PAPER" -> row0 = 110,110,010,110,111.
REQ-043 SHALL verify: target "ABBEY", guess "BOBBY" -> 110,111,010,111,010 (duplicate consumption).
REQ-044 SHALL verify: six non-matching guesses -> lose=1 after the 6th score_done; a 7th guess_valid is ignored and guess_count stays 6.
REQ-045 SHALL verify: new_game pulsed during YELLOW -> no score_done; all reads return 000/8'h20; guess_ready=1 the next cycle.
REQ-046 SHALL verify: rd_row=7, rd_col=2 -> 000/8'h20; reset asserted mid-scoring -> guess_count=0 and row0 EMPTY.
